logo_motion_ctrl: RTL and testbench

Frame-synchronous motion controller for the bouncing VGA logo sprite. Generates the sprite's top-left position (logo_x, logo_y) and advances it once every N frames. Reverses direction at the screen edges. Exposes a small CPU write port for run/hold/single-step control, speed and position preset. Sits between the CPU bus and the pixel-stage logo renderer, and replaces free-running position logic in the renderer.

---
 rtl/logo_motion_ctrl_pkg.sv | 52 +++++
 rtl/logo_motion_ctrl_if.sv | 16 +
 rtl/logo_motion_ctrl_axis.sv | 47 ++++
 rtl/logo_motion_ctrl.sv | 154 +++++++++++++++
 tb/tb_logo_motion_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/logo_motion_ctrl_pkg.sv
// Shared constants and types for the bouncing-logo motion controller.
//   - screen and sprite geometry, derived position bounds
//   - state encoding (HOLD/RUN/STEP)
//   - CPU register addresses (CFG_CTRL/CFG_SPEED/CFG_SETX/CFG_SETY)
//   - dir bit positions and meanings
//   - clamp_pos(): limits a preset value to an axis bound
package logo_motion_ctrl_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned LOGO_W   = 100;
   localparam int unsigned LOGO_H   = 125;
   localparam int unsigned STEP     = 1;
   localparam int unsigned INIT_X   = 430;
   localparam int unsigned INIT_Y   = 50;
   localparam int unsigned V_TRIG   = 480;

   localparam int unsigned POS_W    = 10;
   localparam int unsigned SPEED_W  = 8;
   localparam int unsigned BCNT_W   = 16;

   // Largest legal top-left coordinate per axis
   localparam int unsigned X_MAX    = H_ACTIVE - LOGO_W;   // 540
   localparam int unsigned Y_MAX    = V_ACTIVE - LOGO_H;   // 355

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [1:0] CFG_CTRL  = 2'd0;
   localparam logic [1:0] CFG_SPEED = 2'd1;
   localparam logic [1:0] CFG_SETX  = 2'd2;
   localparam logic [1:0] CFG_SETY  = 2'd3;

   // dir[DIR_X_BIT] = 1: moving left; dir[DIR_Y_BIT] = 1: moving up
   localparam int unsigned DIR_X_BIT = 1;
   localparam int unsigned DIR_Y_BIT = 0;
   localparam logic [1:0]  DIR_INIT  = 2'b01;

   // CTRL register bits
   localparam int unsigned CTRL_RUN_BIT    = 0;
   localparam int unsigned CTRL_STEP_BIT   = 1;
   localparam int unsigned CTRL_RELOAD_BIT = 2;

   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                  input logic [POS_W-1:0] max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/logo_motion_ctrl_if.sv
// CPU configuration write port of the logo motion controller.
//   we    : one-pclk write strobe
//   addr  : register select (CTRL, SPEED, SETX, SETY)
//   wdata : write data
// master = CPU side, slave = controller side.
interface logo_motion_ctrl_if;
   import logo_motion_ctrl_pkg::*;

   logic              we;
   logic [1:0]        addr;
   logic [POS_W-1:0]  wdata;

   modport master (output we, output addr, output wdata);
   modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/logo_motion_ctrl_axis.sv
// Single-axis step / edge-reflect unit (purely combinational).
//   pos       : current coordinate
//   dec       : 1 = coordinate decreasing
//   pos_nxt_c : coordinate after one move
//   flip_c    : move crossed an edge; direction must reverse
// An overshoot is mirrored back off the edge, so a sprite at the edge moves
// STEP pixels inward on the reflecting move (0 -> 1, MAX -> MAX-1).
module axis_bounce
   import logo_motion_ctrl_pkg::*;
#(
   parameter int unsigned MAX = 540
) (
   input  logic [POS_W-1:0] pos,
   input  logic             dec,
   output logic [POS_W-1:0] pos_nxt_c,
   output logic             flip_c
);

   localparam int unsigned CW = POS_W + 1;

   logic [CW-1:0] sum_c;
   logic [CW-1:0] diff_c;

   always_comb begin
      sum_c     = CW'(pos) + CW'(STEP);
      diff_c    = CW'(pos) - CW'(STEP);
      pos_nxt_c = pos;
      flip_c    = 1'b0;
      if (dec) begin
         // borrow into the top bit means we went below zero
         if (diff_c[CW-1]) begin
            pos_nxt_c = POS_W'(CW'(STEP) - CW'(pos));
            flip_c    = 1'b1;
         end else begin
            pos_nxt_c = diff_c[POS_W-1:0];
         end
      end else begin
         if (sum_c > CW'(MAX)) begin
            pos_nxt_c = POS_W'(CW'(2 * MAX) - sum_c);
            flip_c    = 1'b1;
         end else begin
            pos_nxt_c = sum_c[POS_W-1:0];
         end
      end
   end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Frame-synchronous motion controller for the bouncing logo sprite.
// Ports:
//   pclk, rst       : pixel clock, synchronous active-high reset
//   h_cnt, v_cnt    : VGA timing counters
//   cfg             : CPU write port (logo_motion_ctrl_if.slave)
//   logo_x, logo_y  : sprite top-left position
//   dir             : bit1 moving left, bit0 moving up
//   state           : 0 HOLD, 1 RUN, 2 STEP
//   frame_tick      : one-pclk pulse at frame start
//   bounce          : one-pclk pulse on any edge reflection
//   bounce_cnt      : reflection count (only with LOGO_BOUNCE_CNT_EN defined,
//                     otherwise tied to zero)
module logo_motion_ctrl
   import logo_motion_ctrl_pkg::*;
(
   input  logic                  pclk,
   input  logic                  rst,
   input  logic [9:0]            h_cnt,
   input  logic [9:0]            v_cnt,
   logo_motion_ctrl_if.slave     cfg,
   output logic [POS_W-1:0]      logo_x,
   output logic [POS_W-1:0]      logo_y,
   output logic [1:0]            dir,
   output logic [1:0]            state,
   output logic                  frame_tick,
   output logic                  bounce,
   output logic [BCNT_W-1:0]     bounce_cnt
);

   state_t               state_q, state_nxt;
   logic [SPEED_W-1:0]   speed_q;
   logic [SPEED_W-1:0]   div_q;

   logic                 frame_start_c;
   logic                 move_evt_c;
   logic                 moving_c;
   logic                 wr_ctrl_c, wr_speed_c, wr_setx_c, wr_sety_c;
   logic                 reload_c;
   logic                 x_apply_c, y_apply_c;
   logic                 bounce_nxt_c;
   logic [POS_W-1:0]     x_step_c, y_step_c;
   logic                 x_flip_c, y_flip_c;

   // Frame start, CPU write decode and move qualification
   always_comb begin
      frame_start_c = (v_cnt == 10'(V_TRIG)) && (h_cnt == 10'd0);
      move_evt_c    = frame_tick && (div_q == speed_q);
      moving_c      = move_evt_c && ((state_q == ST_RUN) || (state_q == ST_STEP));
      wr_ctrl_c     = cfg.we && (cfg.addr == CFG_CTRL);
      wr_speed_c    = cfg.we && (cfg.addr == CFG_SPEED);
      wr_setx_c     = cfg.we && (cfg.addr == CFG_SETX);
      wr_sety_c     = cfg.we && (cfg.addr == CFG_SETY);
      reload_c      = wr_ctrl_c && cfg.wdata[CTRL_RELOAD_BIT];
      // a CPU preset of an axis drops the move on that axis only
      x_apply_c     = moving_c && !reload_c && !wr_setx_c;
      y_apply_c     = moving_c && !reload_c && !wr_sety_c;
      bounce_nxt_c  = (x_apply_c && x_flip_c) || (y_apply_c && y_flip_c);
   end

   axis_bounce #(.MAX(X_MAX)) u_axis_x (
      .pos       (logo_x),
      .dec       (dir[DIR_X_BIT]),
      .pos_nxt_c (x_step_c),
      .flip_c    (x_flip_c)
   );

   axis_bounce #(.MAX(Y_MAX)) u_axis_y (
      .pos       (logo_y),
      .dec       (dir[DIR_Y_BIT]),
      .pos_nxt_c (y_step_c),
      .flip_c    (y_flip_c)
   );

   // FSM state register
   always_ff @(posedge pclk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_nxt;
   end

   // FSM next state; a CTRL write overrides the STEP completion
   always_comb begin
      state_nxt = state_q;
      if ((state_q == ST_STEP) && moving_c) state_nxt = ST_HOLD;
      if (wr_ctrl_c) begin
         if (cfg.wdata[CTRL_STEP_BIT])     state_nxt = ST_STEP;
         else if (cfg.wdata[CTRL_RUN_BIT]) state_nxt = ST_RUN;
         else                              state_nxt = ST_HOLD;
      end
   end

   assign state = state_q;

   // Frame tick, speed register and frame divider
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_tick <= 1'b0;
         speed_q    <= '0;
         div_q      <= '0;
      end else begin
         frame_tick <= frame_start_c;
         if (wr_speed_c) begin
            speed_q <= cfg.wdata[SPEED_W-1:0];
            div_q   <= '0;
         end else if (frame_tick) begin
            div_q   <= move_evt_c ? '0 : div_q + SPEED_W'(1);
         end
      end
   end

   // Position, direction and bounce pulse
   always_ff @(posedge pclk) begin
      if (rst) begin
         logo_x <= POS_W'(INIT_X);
         logo_y <= POS_W'(INIT_Y);
         dir    <= DIR_INIT;
         bounce <= 1'b0;
      end else begin
         bounce <= bounce_nxt_c;
         if (reload_c) begin
            logo_x <= POS_W'(INIT_X);
            logo_y <= POS_W'(INIT_Y);
            dir    <= DIR_INIT;
         end else begin
            if (wr_setx_c) begin
               logo_x <= clamp_pos(cfg.wdata, POS_W'(X_MAX));
            end else if (x_apply_c) begin
               logo_x <= x_step_c;
               if (x_flip_c) dir[DIR_X_BIT] <= ~dir[DIR_X_BIT];
            end
            if (wr_sety_c) begin
               logo_y <= clamp_pos(cfg.wdata, POS_W'(Y_MAX));
            end else if (y_apply_c) begin
               logo_y <= y_step_c;
               if (y_flip_c) dir[DIR_Y_BIT] <= ~dir[DIR_Y_BIT];
            end
         end
      end
   end

`ifdef LOGO_BOUNCE_CNT_EN
   logic [BCNT_W-1:0] bcnt_q;

   // Saturating reflection counter, counted on the edge the pulse is raised
   always_ff @(posedge pclk) begin
      if (rst || reload_c)                          bcnt_q <= '0;
      else if (bounce_nxt_c && (bcnt_q != '1))      bcnt_q <= bcnt_q + BCNT_W'(1);
   end

   assign bounce_cnt = bcnt_q;
`else
   assign bounce_cnt = '0;
`endif

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Directed self-checking bench for logo_motion_ctrl.
module tb_logo_motion_ctrl;
   import logo_motion_ctrl_pkg::*;

   logic        pclk = 1'b0;
   logic        rst;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [9:0]  logo_x, logo_y;
   logic [1:0]  dir, state;
   logic        frame_tick, bounce;
   logic [15:0] bounce_cnt;

   int errors = 0;
   int checks = 0;

   logo_motion_ctrl_if cfg ();

   logo_motion_ctrl dut (
      .pclk       (pclk),
      .rst        (rst),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .cfg        (cfg),
      .logo_x     (logo_x),
      .logo_y     (logo_y),
      .dir        (dir),
      .state      (state),
      .frame_tick (frame_tick),
      .bounce     (bounce),
      .bounce_cnt (bounce_cnt)
   );

   always #5 pclk = ~pclk;

`ifdef LOGO_BOUNCE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   function automatic logic [31:0] bc_exp(input int n);
      return CNT_EN ? 32'(n) : 32'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [9:0] d);
      @(negedge pclk);
      cfg.we = 1'b1; cfg.addr = a; cfg.wdata = d;
      @(negedge pclk);
      cfg.we = 1'b0;
   endtask

   // One frame start; optionally a CPU write lands in the move-event cycle.
   // Returns at the negedge after the move edge.
   task automatic frame(input logic wr_en, input logic [1:0] a, input logic [9:0] d);
      @(negedge pclk);
      v_cnt = 10'd480; h_cnt = 10'd0;
      @(negedge pclk);
      h_cnt = 10'd1;
      chk("frame_tick_hi", 32'(frame_tick), 32'd1);
      if (wr_en) begin
         cfg.we = 1'b1; cfg.addr = a; cfg.wdata = d;
      end
      @(negedge pclk);
      cfg.we = 1'b0;
      v_cnt  = 10'd10;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0, 2'd0, 10'd0);
   endtask

   initial begin
      rst = 1'b1; h_cnt = 10'd0; v_cnt = 10'd10;
      cfg.we = 1'b0; cfg.addr = 2'd0; cfg.wdata = 10'd0;
      repeat (3) @(negedge pclk);
      rst = 1'b0;

      // reset values
      chk("rst_x", 32'(logo_x), 32'd430);
      chk("rst_y", 32'(logo_y), 32'd50);
      chk("rst_dir", 32'(dir), 32'd1);
      chk("rst_state", 32'(state), 32'd1);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      chk("rst_bounce", 32'(bounce), 32'd0);
      chk("rst_bcnt", 32'(bounce_cnt), 32'd0);

      // one frame at speed 0
      frames(1);
      chk("f1_x", 32'(logo_x), 32'd431);
      chk("f1_y", 32'(logo_y), 32'd49);
      chk("f1_dir", 32'(dir), 32'd1);
      chk("f1_tick_lo", 32'(frame_tick), 32'd0);

      // right-edge reflection
      wr(CFG_SETX, 10'd539);
      chk("setx_x", 32'(logo_x), 32'd539);
      chk("setx_dir", 32'(dir), 32'd1);
      frames(1);
      chk("edge_x540", 32'(logo_x), 32'd540);
      chk("edge_nobounce", 32'(bounce), 32'd0);
      frames(1);
      chk("edge_x539", 32'(logo_x), 32'd539);
      chk("edge_dir", 32'(dir), 32'd3);
      chk("edge_y", 32'(logo_y), 32'd47);
      chk("edge_bounce", 32'(bounce), 32'd1);
      @(negedge pclk);
      chk("edge_bounce_once", 32'(bounce), 32'd0);
      chk("edge_bcnt", 32'(bounce_cnt), bc_exp(1));

      // corner reflection
      wr(CFG_SETX, 10'd0);
      wr(CFG_SETY, 10'd0);
      frames(1);
      chk("corner_x", 32'(logo_x), 32'd1);
      chk("corner_y", 32'(logo_y), 32'd1);
      chk("corner_dir", 32'(dir), 32'd0);
      chk("corner_bounce", 32'(bounce), 32'd1);
      @(negedge pclk);
      chk("corner_bounce_once", 32'(bounce), 32'd0);
      chk("corner_bcnt", 32'(bounce_cnt), bc_exp(2));

      // preset clamping
      wr(CFG_SETX, 10'd1000);
      chk("clamp_x", 32'(logo_x), 32'd540);
      wr(CFG_SETY, 10'd1000);
      chk("clamp_y", 32'(logo_y), 32'd355);

      // speed 3: one move per 4 frame ticks
      wr(CFG_SETX, 10'd100);
      wr(CFG_SETY, 10'd100);
      wr(CFG_SPEED, 10'd3);
      frames(3);
      chk("spd_f3_x", 32'(logo_x), 32'd100);
      frames(1);
      chk("spd_f4_x", 32'(logo_x), 32'd101);
      frames(8);
      chk("spd_f12_x", 32'(logo_x), 32'd103);
      chk("spd_f12_y", 32'(logo_y), 32'd103);

      // hold and single step
      wr(CFG_SPEED, 10'd0);
      wr(CFG_CTRL, 10'd0);
      chk("hold_state", 32'(state), 32'd0);
      frames(5);
      chk("hold_x", 32'(logo_x), 32'd103);
      chk("hold_y", 32'(logo_y), 32'd103);
      wr(CFG_CTRL, 10'd2);
      chk("step_state", 32'(state), 32'd2);
      frames(1);
      chk("step_x", 32'(logo_x), 32'd104);
      chk("step_y", 32'(logo_y), 32'd104);
      chk("step_done_state", 32'(state), 32'd0);
      frames(1);
      chk("step_once_x", 32'(logo_x), 32'd104);

      // reload together with a move event
      wr(CFG_CTRL, 10'd1);
      chk("run_state", 32'(state), 32'd1);
      frame(1'b1, CFG_CTRL, 10'd5);
      chk("reload_x", 32'(logo_x), 32'd430);
      chk("reload_y", 32'(logo_y), 32'd50);
      chk("reload_dir", 32'(dir), 32'd1);
      chk("reload_state", 32'(state), 32'd1);
      chk("reload_bounce", 32'(bounce), 32'd0);
      chk("reload_bcnt", 32'(bounce_cnt), 32'd0);
      frames(1);
      chk("post_reload_x", 32'(logo_x), 32'd431);
      chk("post_reload_y", 32'(logo_y), 32'd49);

      // SETX together with a move event: only x preset, y still moves
      frame(1'b1, CFG_SETX, 10'd200);
      chk("setx_mv_x", 32'(logo_x), 32'd200);
      chk("setx_mv_y", 32'(logo_y), 32'd48);
      chk("setx_mv_dir", 32'(dir), 32'd1);

      // reset mid divider period
      wr(CFG_SPEED, 10'd2);
      frames(1);
      chk("div_nomove_y", 32'(logo_y), 32'd48);
      @(negedge pclk); rst = 1'b1;
      @(negedge pclk); rst = 1'b0;
      chk("rst2_x", 32'(logo_x), 32'd430);
      chk("rst2_y", 32'(logo_y), 32'd50);
      chk("rst2_state", 32'(state), 32'd1);
      frames(1);
      chk("rst2_f1_x", 32'(logo_x), 32'd431);
      chk("rst2_f1_y", 32'(logo_y), 32'd49);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
